axi_master_arbiter: RTL and testbench

- Parametrised N-to-1 AXI3 master arbiter; successor to the fixed three-port CPU top (icache, dcache and uncached ports each brought out separately).
- Merges N_MASTERS CPU-side AXI master ports (icache, dcache, duncache, future TLB walker, …) onto one SoC AXI master port.
- Read and write directions are arbitrated independently. One outstanding burst per direction, so the grant register routes R and B without any ID remapping.

---
 rtl/axi_master_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_axi_master_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_arbiter.sv
// N-to-1 AXI3 master arbiter with independent read/write grants, one burst in flight per direction.
// Define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module axi_master_arbiter #(
  parameter int N_MASTERS = 3,
  parameter int BUS_WIDTH = 4,
  parameter int IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                                  aclk,
  input  logic                                  rst_n,
  input  logic [N_MASTERS*(BUS_WIDTH+50)-1:0]   s_ar_req,
  input  logic [N_MASTERS-1:0]                  s_arvalid,
  output logic [N_MASTERS-1:0]                  s_arready,
  output logic [BUS_WIDTH+34:0]                 s_r,
  output logic [N_MASTERS-1:0]                  s_rvalid,
  input  logic [N_MASTERS-1:0]                  s_rready,
  input  logic [N_MASTERS*(BUS_WIDTH+50)-1:0]   s_aw_req,
  input  logic [N_MASTERS-1:0]                  s_awvalid,
  output logic [N_MASTERS-1:0]                  s_awready,
  input  logic [N_MASTERS*(BUS_WIDTH+37)-1:0]   s_w,
  input  logic [N_MASTERS-1:0]                  s_wvalid,
  output logic [N_MASTERS-1:0]                  s_wready,
  output logic [BUS_WIDTH+1:0]                  s_b,
  output logic [N_MASTERS-1:0]                  s_bvalid,
  input  logic [N_MASTERS-1:0]                  s_bready,
  output logic [BUS_WIDTH+49:0]                 m_ar_req,
  output logic                                  m_arvalid,
  input  logic                                  m_arready,
  input  logic [BUS_WIDTH+34:0]                 m_r,
  input  logic                                  m_rvalid,
  output logic                                  m_rready,
  output logic [BUS_WIDTH+49:0]                 m_aw_req,
  output logic                                  m_awvalid,
  input  logic                                  m_awready,
  output logic [BUS_WIDTH+36:0]                 m_w,
  output logic                                  m_wvalid,
  input  logic                                  m_wready,
  input  logic [BUS_WIDTH+1:0]                  m_b,
  input  logic                                  m_bvalid,
  output logic                                  m_bready
);

  localparam int AR_W = BUS_WIDTH + 50;
  localparam int W_W  = BUS_WIDTH + 37;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rstate_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wstate_e;

  rstate_e              rstate_q;
  wstate_e              wstate_q;
  logic [IDX_W-1:0]     rgnt_q, wgnt_q;
  logic [IDX_W-1:0]     rwin_s, wwin_s;
  logic [N_MASTERS-1:0] rsel_s, wsel_s;

`ifdef ARB_FIXED_PRIO_EN
  function automatic logic [IDX_W-1:0] pick(input logic [N_MASTERS-1:0] req);
    logic [IDX_W-1:0] win;
    win = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (req[k]) win = IDX_W'(k);
    end
    return win;
  endfunction

  assign rwin_s = pick(s_arvalid);
  assign wwin_s = pick(s_awvalid);
`else
  logic [IDX_W-1:0] rptr_q, wptr_q;

  // First asserted request at or above the pointer, wrapping past the top index.
  function automatic logic [IDX_W-1:0] pick(input logic [N_MASTERS-1:0] req,
                                            input logic [IDX_W-1:0]     ptr);
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!found && req[idx]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(N_MASTERS - 1)) ? '0 : g + IDX_W'(1);
  endfunction

  assign rwin_s = pick(s_arvalid, rptr_q);
  assign wwin_s = pick(s_awvalid, wptr_q);
`endif

  // Read direction FSM and grant register
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      rgnt_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rptr_q   <= '0;
`endif
    end else begin
      case (rstate_q)
        R_IDLE: if (|s_arvalid) begin
          rgnt_q   <= rwin_s;
          rstate_q <= R_ADDR;
        end
        R_ADDR: if (m_arvalid && m_arready) rstate_q <= R_DATA;
        R_DATA: if (m_rvalid && m_rready && m_r[0]) begin
`ifndef ARB_FIXED_PRIO_EN
          rptr_q   <= nxt(rgnt_q);
`endif
          rstate_q <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // Write direction FSM and grant register
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q <= W_IDLE;
      wgnt_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      wptr_q   <= '0;
`endif
    end else begin
      case (wstate_q)
        W_IDLE: if (|s_awvalid) begin
          wgnt_q   <= wwin_s;
          wstate_q <= W_ADDR;
        end
        W_ADDR: if (m_awvalid && m_awready) wstate_q <= W_DATA;
        W_DATA: if (m_wvalid && m_wready && m_w[0]) wstate_q <= W_RESP;
        W_RESP: if (m_bvalid && m_bready) begin
`ifndef ARB_FIXED_PRIO_EN
          wptr_q   <= nxt(wgnt_q);
`endif
          wstate_q <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Payload muxes are AND-OR of one-hot grant selects so an idle grant still drives known data
  always_comb begin
    rsel_s   = '0;
    wsel_s   = '0;
    m_ar_req = '0;
    m_aw_req = '0;
    m_w      = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      rsel_s[i] = (rgnt_q == IDX_W'(i));
      wsel_s[i] = (wgnt_q == IDX_W'(i));
      m_ar_req  = m_ar_req | (s_ar_req[i*AR_W +: AR_W] & {AR_W{rsel_s[i]}});
      m_aw_req  = m_aw_req | (s_aw_req[i*AR_W +: AR_W] & {AR_W{wsel_s[i]}});
      m_w       = m_w      | (s_w[i*W_W +: W_W]        & {W_W{wsel_s[i]}});
    end
  end

  // Handshake routing gated by FSM state
  always_comb begin
    m_arvalid = (rstate_q == R_ADDR) && (|(s_arvalid & rsel_s));
    s_arready = ((rstate_q == R_ADDR) && m_arready) ? rsel_s : '0;
    s_rvalid  = ((rstate_q == R_DATA) && m_rvalid) ? rsel_s : '0;
    m_rready  = (rstate_q == R_DATA) && (|(s_rready & rsel_s));
    s_r       = m_r;
    m_awvalid = (wstate_q == W_ADDR) && (|(s_awvalid & wsel_s));
    s_awready = ((wstate_q == W_ADDR) && m_awready) ? wsel_s : '0;
    m_wvalid  = (wstate_q == W_DATA) && (|(s_wvalid & wsel_s));
    s_wready  = ((wstate_q == W_DATA) && m_wready) ? wsel_s : '0;
    s_bvalid  = ((wstate_q == W_RESP) && m_bvalid) ? wsel_s : '0;
    m_bready  = (wstate_q == W_RESP) && (|(s_bready & wsel_s));
    s_b       = m_b;
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter (3 masters, 4-bit IDs); the bench plays both CPU masters and SoC slave.
module tb_axi_master_arbiter;
  localparam int N    = 3;
  localparam int BW   = 4;
  localparam int AR_W = BW + 50;
  localparam int R_W  = BW + 35;
  localparam int W_W  = BW + 37;
  localparam int B_W  = BW + 2;

  logic             aclk, rst_n;
  logic [N*AR_W-1:0] s_ar_req, s_aw_req;
  logic [N*W_W-1:0]  s_w;
  logic [N-1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [R_W-1:0]    s_r, m_r;
  logic [B_W-1:0]    s_b, m_b;
  logic [AR_W-1:0]   m_ar_req, m_aw_req;
  logic [W_W-1:0]    m_w;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic m_wvalid, m_wready, m_bvalid, m_bready;

  int total = 0;
  int bad   = 0;

  axi_master_arbiter #(.N_MASTERS(N), .BUS_WIDTH(BW)) dut (
    .aclk(aclk), .rst_n(rst_n),
    .s_ar_req(s_ar_req), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_r(s_r), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_aw_req(s_aw_req), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_w(s_w), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_b(s_b), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_ar_req(m_ar_req), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_r(m_r), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_aw_req(m_aw_req), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_w(m_w), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_b(m_b), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [AR_W-1:0] mk_ax(input logic [3:0] id, input logic [31:0] addr,
                                            input logic [3:0] len);
    return {id, addr, len, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0};
  endfunction

  function automatic logic [R_W-1:0] mk_r(input logic [3:0] id, input logic [31:0] d,
                                          input logic last);
    return {id, d, 2'b00, last};
  endfunction

  function automatic logic [W_W-1:0] mk_w(input logic [3:0] id, input logic [31:0] d,
                                          input logic last);
    return {id, d, 4'hF, last};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    s_ar_req = '0; s_aw_req = '0; s_w = '0;
    s_arvalid = '0; s_rready = '0; s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    m_arready = 1'b0; m_r = '0; m_rvalid = 1'b0; m_awready = 1'b0;
    m_wready = 1'b0; m_b = '0; m_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge aclk);
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_id;
  logic       found;
  int         beat, stall;

  initial begin
    // Reset with busy-looking inputs: every valid/ready output must stay low
    clear_inputs();
    rst_n = 1'b0;
    s_arvalid = 3'b111; s_awvalid = 3'b111; s_wvalid = 3'b111;
    s_rready = 3'b111; s_bready = 3'b111;
    m_arready = 1'b1; m_rvalid = 1'b1; m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    @(negedge aclk); @(negedge aclk); #1;
    chk("rst_m_arvalid", m_arvalid, 1'b0);
    chk("rst_m_awvalid", m_awvalid, 1'b0);
    chk("rst_s_arready", s_arready, 3'b000);
    chk("rst_s_rvalid", s_rvalid, 3'b000);
    chk("rst_s_wready", s_wready, 3'b000);
    chk("rst_s_bvalid", s_bvalid, 3'b000);
    chk("rst_m_rready", m_rready, 1'b0);
    chk("rst_m_bready", m_bready, 1'b0);
    do_reset();

    // Single read from master 1, len 3
    @(negedge aclk);
    s_ar_req[1*AR_W +: AR_W] = mk_ax(4'd1, 32'h1FC0_0000, 4'd3);
    s_arvalid = 3'b010;
    #1 chk("rd_idle_arvalid", m_arvalid, 1'b0);
    @(negedge aclk); #1;
    chk("rd_arvalid_t1", m_arvalid, 1'b1);
    chk("rd_ar_req", m_ar_req, mk_ax(4'd1, 32'h1FC0_0000, 4'd3));
    chk("rd_arready_wait", s_arready, 3'b000);
    m_arready = 1'b1;
    #1 chk("rd_arready", s_arready, 3'b010);
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      s_arvalid = '0; m_arready = 1'b0; s_rready = 3'b010;
      m_rvalid = 1'b1; m_r = mk_r(4'd1, 32'h1000_0000 + 32'(k), k == 3);
      #1;
      chk("rd_rvalid", s_rvalid, 3'b010);
      chk("rd_rready", m_rready, 1'b1);
      chk("rd_r", s_r, mk_r(4'd1, 32'h1000_0000 + 32'(k), k == 3));
    end
    @(negedge aclk); #1;
    chk("rd_back_idle", s_rvalid, 3'b000);
    chk("rd_idle_rready", m_rready, 1'b0);
    m_rvalid = 1'b0; s_rready = '0;

    // Fairness: all three masters keep asking for len-0 reads
    do_reset();
    for (int i = 0; i < N; i++) s_ar_req[i*AR_W +: AR_W] = mk_ax(4'(i), 32'h0000_0100, 4'd0);
    s_arvalid = 3'b111; m_arready = 1'b1; s_rready = 3'b111;
    m_rvalid = 1'b1; m_r = mk_r(4'd0, 32'd0, 1'b1);
    for (int n = 0; n < 6; n++) begin
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge aclk); #1;
        if (m_arvalid) found = 1'b1;
      end
      chk("rr_found", found, 1'b1);
`ifdef ARB_FIXED_PRIO_EN
      exp_id = 4'd0;
`else
      exp_id = 4'(n % 3);
`endif
      chk("rr_grant_id", m_ar_req[AR_W-1 -: BW], exp_id);
      chk("rr_arready", s_arready, 3'b001 << exp_id);
    end
    @(negedge aclk);
    s_arvalid = '0;
    @(negedge aclk);
    m_rvalid = 1'b0; m_arready = 1'b0; s_rready = '0;
    #1 chk("rr_quiet", m_arvalid, 1'b0);

    // Write from master 2: W offered early must wait for the AW handshake
    do_reset();
    @(negedge aclk);
    s_aw_req[2*AR_W +: AR_W] = mk_ax(4'd2, 32'h0000_1000, 4'd1);
    s_awvalid = 3'b100;
    s_w[2*W_W +: W_W] = mk_w(4'd2, 32'hAAAA_AAAA, 1'b0);
    s_wvalid = 3'b100; m_wready = 1'b1;
    #1;
    chk("wr_idle_wready", s_wready, 3'b000);
    chk("wr_idle_wvalid", m_wvalid, 1'b0);
    @(negedge aclk); #1;
    chk("wr_awvalid", m_awvalid, 1'b1);
    chk("wr_aw_req", m_aw_req, mk_ax(4'd2, 32'h0000_1000, 4'd1));
    chk("wr_addr_wready", s_wready, 3'b000);
    m_awready = 1'b1;
    #1;
    chk("wr_awready", s_awready, 3'b100);
    chk("wr_hs_wready", s_wready, 3'b000);
    @(negedge aclk);
    s_awvalid = '0; m_awready = 1'b0;
    #1;
    chk("wr_beat0_valid", m_wvalid, 1'b1);
    chk("wr_beat0", m_w, mk_w(4'd2, 32'hAAAA_AAAA, 1'b0));
    chk("wr_beat0_ready", s_wready, 3'b100);
    @(negedge aclk);
    s_w[2*W_W +: W_W] = mk_w(4'd2, 32'h5555_5555, 1'b1);
    #1;
    chk("wr_beat1", m_w, mk_w(4'd2, 32'h5555_5555, 1'b1));
    chk("wr_beat1_ready", s_wready, 3'b100);
    @(negedge aclk);
    s_wvalid = '0; m_wready = 1'b1;
    m_bvalid = 1'b1; m_b = {4'd2, 2'b00}; s_bready = 3'b100;
    #1;
    chk("wr_bvalid", s_bvalid, 3'b100);
    chk("wr_b", s_b, 6'h08);
    chk("wr_bready", m_bready, 1'b1);
    chk("wr_resp_wready", s_wready, 3'b000);
    @(negedge aclk); #1;
    chk("wr_back_idle", s_bvalid, 3'b000);
    m_bvalid = 1'b0; s_bready = '0; m_wready = 1'b0;

    // Concurrent read (master 0) and write (master 1)
    @(negedge aclk);
    s_ar_req[0*AR_W +: AR_W] = mk_ax(4'd0, 32'h0000_2000, 4'd0);
    s_aw_req[1*AR_W +: AR_W] = mk_ax(4'd1, 32'h0000_3000, 4'd0);
    s_arvalid = 3'b001; s_awvalid = 3'b010;
    @(negedge aclk); #1;
    chk("cc_arvalid", m_arvalid, 1'b1);
    chk("cc_awvalid", m_awvalid, 1'b1);
    chk("cc_ar_id", m_ar_req[AR_W-1 -: BW], 4'd0);
    chk("cc_aw_id", m_aw_req[AR_W-1 -: BW], 4'd1);
    m_arready = 1'b1; m_awready = 1'b1;
    #1;
    chk("cc_arready", s_arready, 3'b001);
    chk("cc_awready", s_awready, 3'b010);
    @(negedge aclk);
    s_arvalid = '0; s_awvalid = '0; m_arready = 1'b0; m_awready = 1'b0;
    m_rvalid = 1'b1; m_r = mk_r(4'd0, 32'hCAFE_0000, 1'b1); s_rready = 3'b111;
    m_bvalid = 1'b1; m_b = {4'd1, 2'b00}; s_bready = 3'b111;
    s_w[1*W_W +: W_W] = mk_w(4'd1, 32'h1234_5678, 1'b1); s_wvalid = 3'b010; m_wready = 1'b1;
    #1;
    chk("cc_rvalid", s_rvalid, 3'b001);
    chk("cc_no_early_b", s_bvalid, 3'b000);
    chk("cc_wready", s_wready, 3'b010);
    @(negedge aclk);
    m_rvalid = 1'b0; s_wvalid = '0; m_wready = 1'b0;
    #1;
    chk("cc_bvalid", s_bvalid, 3'b010);
    chk("cc_no_r", s_rvalid, 3'b000);
    @(negedge aclk);
    m_bvalid = 1'b0; s_bready = '0; s_rready = '0;

    // Backpressure: beat 1 stalled five cycles by s_rready[0]
    @(negedge aclk);
    s_ar_req[0*AR_W +: AR_W] = mk_ax(4'd0, 32'h0000_4000, 4'd3);
    s_arvalid = 3'b001; m_arready = 1'b1;
    @(negedge aclk); #1;
    chk("bp_arvalid", m_arvalid, 1'b1);
    beat = 0; stall = 0;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      @(negedge aclk);
      s_arvalid = '0; m_arready = 1'b0;
      m_rvalid = 1'b1; m_r = mk_r(4'd0, 32'hB000_0000 + 32'(beat), beat == 3);
      s_rready = (beat == 1 && stall < 5) ? 3'b000 : 3'b001;
      #1;
      chk("bp_rvalid", s_rvalid, 3'b001);
      chk("bp_r_stable", s_r, mk_r(4'd0, 32'hB000_0000 + 32'(beat), beat == 3));
      chk("bp_rready", m_rready, s_rready[0]);
      if (m_rready) beat++;
      else stall++;
    end
    chk("bp_beats", beat, 4);
    chk("bp_stalls", stall, 5);
    @(negedge aclk); #1;
    chk("bp_done", s_rvalid, 3'b000);
    m_rvalid = 1'b0; s_rready = '0;

    // Async reset in R_DATA after two beats, then grant restarts from pointer 0
    @(negedge aclk);
    s_ar_req[0*AR_W +: AR_W] = mk_ax(4'd0, 32'h0000_5000, 4'd3);
    s_arvalid = 3'b001; m_arready = 1'b1;
    @(negedge aclk);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      s_arvalid = '0; m_arready = 1'b0; s_rready = 3'b001;
      m_rvalid = 1'b1; m_r = mk_r(4'd0, 32'hD000_0000 + 32'(k), 1'b0);
    end
    #1 chk("ar_pre_rst_rvalid", s_rvalid, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("ar_rst_rvalid", s_rvalid, 3'b000);
    chk("ar_rst_rready", m_rready, 1'b0);
    chk("ar_rst_arvalid", m_arvalid, 1'b0);
    @(negedge aclk);
    clear_inputs();
    rst_n = 1'b1;
    s_ar_req[0*AR_W +: AR_W] = mk_ax(4'd0, 32'h0000_6000, 4'd0);
    s_ar_req[2*AR_W +: AR_W] = mk_ax(4'd2, 32'h0000_7000, 4'd0);
    s_arvalid = 3'b101;
    #1 chk("ar_post_idle", m_arvalid, 1'b0);
    @(negedge aclk); #1;
    chk("ar_post_arvalid", m_arvalid, 1'b1);
    chk("ar_post_id", m_ar_req[AR_W-1 -: BW], 4'd0);
    m_arready = 1'b1;
    #1 chk("ar_post_arready", s_arready, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
